// File: rtl/pcm_fifo_player_if.sv
// FIFO read port seen by the PCM player.
// master pops; slave is the FIFO read side.
interface pcm_fifo_player_if;
  logic       fifo_rd;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/pcm_fifo_player.sv
// Sample-rate FIFO reader feeding an 8-bit PWM DAC.
// PCM_UNDERRUN_MIDSCALE_EN: empty tick loads mid-scale.
module pcm_fifo_player #(
  parameter int unsigned CLK_DIV = 2268
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  pcm_fifo_player_if.master  fifo,
  input  logic               clr_underrun,
  output logic               pwm_out,
  output logic [7:0]         sample,
  output logic               underrun
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt;
  logic        tick;
  state_t      state_q;
  state_t      state_d;
  logic        empty_tick;
  logic        capt;
  logic [7:0]  pend;
  logic [7:0]  pwm_cnt;
  logic        boundary;

  assign tick     = enable && (div_cnt == DIV_LAST);
  assign capt     = (state_q == CAPT);
  assign boundary = (pwm_cnt == 8'hFF);

  assign fifo.fifo_rd = (state_q == READ);

  // sample-rate divider, held at zero while disabled
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // read FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // read FSM next state; enable does not abort a pop
  always_comb begin
    state_d    = state_q;
    empty_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (fifo.fifo_empty) begin
            empty_tick = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pending sample buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 8'h80;
    end else if (capt) begin
      pend <= fifo.fifo_data;
`ifdef PCM_UNDERRUN_MIDSCALE_EN
    end else if (empty_tick) begin
      pend <= 8'h80;
`else
    end else begin
      pend <= pend;
`endif
    end
  end

  // free-running PWM counter and comparator
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < sample);
    end
  end

  // sample swaps only at period end; bypass a same-cycle capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sample <= 8'h80;
    end else if (boundary) begin
      sample <= capt ? fifo.fifo_data : pend;
    end
  end

  // sticky underrun; a new empty tick beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (empty_tick) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_fifo_player.sv
// Directed bench for pcm_fifo_player, CLK_DIV=300.
// Expected values are hand-derived edge numbers.
module tb_pcm_fifo_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clr_underrun;
  logic       pwm_out;
  logic [7:0] sample;
  logic       underrun;

  pcm_fifo_player_if bus ();

  pcm_fifo_player #(.CLK_DIV(300)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo         (bus),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .sample       (sample),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:15];
  int rp = 0;
  int wp = 0;

  assign bus.fifo_empty = (rp == wp);

  // FIFO model: data appears the cycle after rd
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      bus.fifo_data <= mem[rp[3:0]];
      rp <= rp + 1;
    end
  end

  // edges since reset release
  int n = 0;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int rd_cnt = 0;
  int consec = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (bus.fifo_rd) begin
      rd_cnt = rd_cnt + 1;
      if (prev_rd) consec = consec + 1;
    end
    prev_rd = bus.fifo_rd;
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[3:0]] = b;
    wp = wp + 1;
  endtask

  task automatic at_edge(input int e);
    int g;
    g = 0;
    while (n < e && g < 5000) begin
      @(negedge clk);
      g = g + 1;
    end
    if (n != e) begin
      total = total + 1;
      $error("FAIL at_edge: observed %0d expected %0d", n, e);
    end
  endtask

  task automatic count_pwm(output int c);
    c = 0;
    repeat (256) begin
      @(negedge clk);
      c = c + int'(pwm_out);
    end
  endtask

  logic [7:0] idle_val;
  int c;
  int rd_before;

  initial begin
`ifdef PCM_UNDERRUN_MIDSCALE_EN
    idle_val = 8'h80;
`else
    idle_val = 8'h61;
`endif
    reset = 1'b1;
    enable = 1'b0;
    clr_underrun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", 32'(sample), 32'h80);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_rd", 32'(bus.fifo_rd), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);

    push(8'h68);
    push(8'h6F);
    push(8'h6C);
    push(8'h61);
    reset = 1'b0;
    enable = 1'b1;

    count_pwm(c);
    chk("pwm_mid", 32'(c), 32'd128);
    chk("no_rd_early", 32'(rd_cnt), 32'd0);
    at_edge(300);
    chk("rd_300", 32'(bus.fifo_rd), 32'h1);
    at_edge(301);
    chk("rd_301", 32'(bus.fifo_rd), 32'h0);

    at_edge(512);
    chk("s_h", 32'(sample), 32'h68);
    count_pwm(c);
    chk("pwm_h", 32'(c), 32'h68);
    chk("s_o", 32'(sample), 32'h6F);
    count_pwm(c);
    chk("pwm_o", 32'(c), 32'h6F);
    chk("s_l", 32'(sample), 32'h6C);
    count_pwm(c);
    chk("pwm_l", 32'(c), 32'h6C);
    chk("s_a", 32'(sample), 32'h61);
    count_pwm(c);
    chk("pwm_a", 32'(c), 32'h61);

    chk("rd_total4", 32'(rd_cnt), 32'd4);
    chk("underrun_set", 32'(underrun), 32'h1);
    chk("s_under1", 32'(sample), 32'(idle_val));
    at_edge(1792);
    chk("s_under2", 32'(sample), 32'(idle_val));
    clr_underrun = 1'b1;
    at_edge(1793);
    clr_underrun = 1'b0;
    chk("underrun_clr", 32'(underrun), 32'h0);
    at_edge(1800);
    chk("underrun_reset", 32'(underrun), 32'h1);

    at_edge(2049);
    clr_underrun = 1'b1;
    at_edge(2050);
    clr_underrun = 1'b0;
    chk("underrun_clr2", 32'(underrun), 32'h0);
    at_edge(2099);
    clr_underrun = 1'b1;
    at_edge(2100);
    clr_underrun = 1'b0;
    chk("set_wins", 32'(underrun), 32'h1);

    at_edge(2110);
    enable = 1'b0;
    push(8'h20);
    at_edge(2258);
    enable = 1'b1;
    at_edge(2558);
    chk("rd_bypass", 32'(bus.fifo_rd), 32'h1);
    at_edge(2560);
    chk("s_bypass", 32'(sample), 32'h20);
    count_pwm(c);
    chk("pwm_bypass", 32'(c), 32'h20);

    enable = 1'b0;
    push(8'h33);
    rd_before = rd_cnt;
    at_edge(3816);
    chk("en_low_no_rd", 32'(rd_cnt), 32'(rd_before));
    enable = 1'b1;
    at_edge(4116);
    chk("rd_pre_rst", 32'(bus.fifo_rd), 32'h1);
    at_edge(4117);
    reset = 1'b1;
    @(negedge clk);
    chk("rstc_sample", 32'(sample), 32'h80);
    chk("rstc_rd", 32'(bus.fifo_rd), 32'h0);
    chk("rstc_pwm", 32'(pwm_out), 32'h0);
    chk("rstc_underrun", 32'(underrun), 32'h0);
    reset = 1'b0;
    at_edge(256);
    chk("rstc_pend", 32'(sample), 32'h80);
    chk("rstc_underrun2", 32'(underrun), 32'h0);
    chk("rd_consec", 32'(consec), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
